// File: rtl/ibex_cheri_tagged_mem_responder_pkg.sv
// Shared types and helpers for the CHERI tagged data-memory responder.
package ibex_cheri_tagged_mem_responder_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] rdata;
        logic        rtag;
        logic        err;
    } resp_t;

    localparam int unsigned GranuleBytes = 8;

    function automatic int unsigned tag_idx_width(input int unsigned depth_words);
        int unsigned granules;
        granules = depth_words / (GranuleBytes / 4);
        return (granules > 1) ? $clog2(granules) : 1;
    endfunction

endpackage

// File: rtl/ibex_cheri_resp_pipe.sv
// Fixed-depth response shift pipeline; every stage clears on reset so in-flight
// responses are dropped.
module ibex_cheri_resp_pipe
    import ibex_cheri_tagged_mem_responder_pkg::*;
#(
    parameter int unsigned Depth = 1
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  resp_t in_i,
    output resp_t out_o
);

    resp_t stage_q [Depth];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= in_i;
            for (int i = 1; i < Depth; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign out_o = stage_q[Depth-1];

endmodule

// File: rtl/ibex_cheri_tagged_mem_responder.sv
// Word-addressed data memory with one validity tag per 8-byte capability granule.
// Define IBEX_CHERI_TAGMEM_ERR_EN to reject out-of-range addresses with an error response.
module ibex_cheri_tagged_mem_responder
    import ibex_cheri_tagged_mem_responder_pkg::*;
#(
    parameter int unsigned MemDepthWords = 4096,
    parameter logic [31:0] BaseAddr      = 32'h0010_0000,
    parameter int unsigned RespLatency   = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    input  logic        data_cap_i,
    input  logic        data_wtag_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_rtag_o,
    output logic        data_err_o
);

    localparam int unsigned WordIdxW    = $clog2(MemDepthWords);
    localparam int unsigned AddrW       = WordIdxW + 2;
    localparam int unsigned NumGranules = MemDepthWords / (GranuleBytes / 4);
    localparam int unsigned TagIdxW     = tag_idx_width(MemDepthWords);

    logic [31:0]         offset;
    logic [WordIdxW-1:0] word_idx;
    logic [TagIdxW-1:0]  gran_idx;
    logic                upper_word;
    logic                in_range;
    logic                write_en;
    logic                unused_offset;

    // BaseAddr is aligned to the array size, so the offset's low bits are the index.
    assign offset        = data_addr_i - BaseAddr;
    assign word_idx      = offset[AddrW-1:2];
    assign gran_idx      = TagIdxW'(word_idx >> 1);
    assign upper_word    = data_addr_i[2];
    assign unused_offset = ^{offset[31:AddrW], offset[1:0]};

`ifdef IBEX_CHERI_TAGMEM_ERR_EN
    assign in_range = (offset < 32'(4 * MemDepthWords));
`else
    assign in_range = 1'b1;
`endif

    assign data_gnt_o = data_req_i & rst_ni;
    assign write_en   = data_gnt_o & data_we_i & in_range;

    logic [31:0] mem_q [MemDepthWords];

    always_ff @(posedge clk_i) begin
        if (write_en) begin
            for (int b = 0; b < 4; b++) begin
                if (data_be_i[b]) begin
                    mem_q[word_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
                end
            end
        end
    end

    logic [NumGranules-1:0] tag_q, tag_d;

    // Only a full-width upper-word capability store can leave a granule tagged.
    always_comb begin
        tag_d = tag_q;
        if (write_en) begin
            tag_d[gran_idx] = data_cap_i & upper_word & data_wtag_i & (data_be_i == 4'hF);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tag_q <= '0;
        end else begin
            tag_q <= tag_d;
        end
    end

    resp_t resp_d;
    resp_t resp_out;
    logic  load_ok;

    assign load_ok = data_gnt_o & ~data_we_i & in_range;

    always_comb begin
        resp_d       = '0;
        resp_d.valid = data_gnt_o;
        resp_d.rdata = load_ok ? mem_q[word_idx] : 32'h0;
        resp_d.rtag  = load_ok & data_cap_i & tag_q[gran_idx];
        resp_d.err   = data_gnt_o & ~in_range;
    end

    ibex_cheri_resp_pipe #(
        .Depth(RespLatency)
    ) u_resp_pipe (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .in_i  (resp_d),
        .out_o (resp_out)
    );

    assign data_rvalid_o = resp_out.valid;
    assign data_rdata_o  = resp_out.rdata;
    assign data_rtag_o   = resp_out.rtag;
    assign data_err_o    = resp_out.err;

endmodule

// File: tb/tb_ibex_cheri_tagged_mem_responder.sv
// Scoreboard bench for the tagged memory responder (RespLatency = 3, 64-word array).
module tb_ibex_cheri_tagged_mem_responder;

    localparam int unsigned Depth = 64;
    localparam logic [31:0] Base  = 32'h0010_0000;
    localparam int unsigned Lat   = 3;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        data_req_i;
    logic        data_gnt_o;
    logic [31:0] data_addr_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_wdata_i;
    logic        data_cap_i;
    logic        data_wtag_i;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_rtag_o;
    logic        data_err_o;

    always #5 clk_i = ~clk_i;

    ibex_cheri_tagged_mem_responder #(
        .MemDepthWords(Depth),
        .BaseAddr     (Base),
        .RespLatency  (Lat)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .data_req_i   (data_req_i),
        .data_gnt_o   (data_gnt_o),
        .data_addr_i  (data_addr_i),
        .data_we_i    (data_we_i),
        .data_be_i    (data_be_i),
        .data_wdata_i (data_wdata_i),
        .data_cap_i   (data_cap_i),
        .data_wtag_i  (data_wtag_i),
        .data_rvalid_o(data_rvalid_o),
        .data_rdata_o (data_rdata_o),
        .data_rtag_o  (data_rtag_o),
        .data_err_o   (data_err_o)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        rtag;
        logic        err;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem_m [Depth];
    logic        tag_m [Depth/2];
    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned cyc      = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        exp_t e;
        if (rst_ni && data_rvalid_o) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_rvalid: rvalid=1 at cycle %0d, required 0", cyc);
            end else begin
                e = sb.pop_front();
                n_checks += 3;
                if (data_rdata_o !== e.rdata) begin
                    n_fail++;
                    $display("FAIL rdata: got %h required %h", data_rdata_o, e.rdata);
                end
                if (data_rtag_o !== e.rtag) begin
                    n_fail++;
                    $display("FAIL rtag: got %b required %b (rdata %h)", data_rtag_o, e.rtag,
                             e.rdata);
                end
                if (data_err_o !== e.err) begin
                    n_fail++;
                    $display("FAIL err: got %b required %b", data_err_o, e.err);
                end
                if (cyc !== e.cyc + Lat) begin
                    n_fail++;
                    $display("FAIL latency: rvalid at cycle %0d required %0d", cyc, e.cyc + Lat);
                end
            end
        end
    end

    task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wdata, input logic cap, input logic wtag);
        exp_t        e;
        int unsigned idx;
        int unsigned gidx;
        logic [31:0] off;
        logic        inr;
        @(negedge clk_i);
        data_req_i   = 1'b1;
        data_we_i    = we;
        data_addr_i  = addr;
        data_be_i    = be;
        data_wdata_i = wdata;
        data_cap_i   = cap;
        data_wtag_i  = wtag;
        off  = addr - Base;
        idx  = (off >> 2) % Depth;
        gidx = idx / 2;
`ifdef IBEX_CHERI_TAGMEM_ERR_EN
        inr = (addr >= Base) && (addr < Base + 4 * Depth);
`else
        inr = 1'b1;
`endif
        e.cyc = cyc;
        e.err = !inr;
        if (we) begin
            e.rdata = '0;
            e.rtag  = 1'b0;
            if (inr) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) mem_m[idx][8*b +: 8] = wdata[8*b +: 8];
                end
                tag_m[gidx] = cap && addr[2] && wtag && (be == 4'hF);
            end
        end else begin
            e.rdata = inr ? mem_m[idx] : 32'h0;
            e.rtag  = inr && cap && tag_m[gidx];
        end
        sb.push_back(e);
        #1;
        n_checks++;
        if (data_gnt_o !== 1'b1) begin
            n_fail++;
            $display("FAIL gnt: got %b required 1 for addr %h", data_gnt_o, addr);
        end
    endtask

    task automatic idle();
        @(negedge clk_i);
        data_req_i = 1'b0;
        data_we_i  = 1'b0;
        data_cap_i = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        idle();
        while (sb.size() != 0 && k < 20) begin
            @(negedge clk_i);
            k++;
        end
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst_ni       = 1'b0;
        data_req_i   = 1'b1;
        data_we_i    = 1'b0;
        data_addr_i  = Base;
        data_be_i    = 4'hF;
        data_wdata_i = '0;
        data_cap_i   = 1'b0;
        data_wtag_i  = 1'b0;
        for (int i = 0; i < Depth / 2; i++) tag_m[i] = 1'b0;
        repeat (3) @(negedge clk_i);
        n_checks += 5;
        if (data_gnt_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_gnt: got %b required 0", data_gnt_o);
        end
        if (data_rvalid_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_rvalid: got %b required 0", data_rvalid_o);
        end
        if (data_rdata_o !== 32'h0) begin
            n_fail++; $display("FAIL reset_rdata: got %h required 0", data_rdata_o);
        end
        if (data_rtag_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_rtag: got %b required 0", data_rtag_o);
        end
        if (data_err_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_err: got %b required 0", data_err_o);
        end
        data_req_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_cap_tag();
        issue(1'b1, Base,     4'hF, 32'h1111_2222, 1'b1, 1'b0);
        issue(1'b1, Base + 4, 4'hF, 32'h3333_4444, 1'b1, 1'b1);
        issue(1'b0, Base,     4'hF, 32'h0,         1'b1, 1'b0);
        issue(1'b0, Base + 4, 4'hF, 32'h0,         1'b1, 1'b0);
        drain();
    endtask

    task automatic test_byte_store();
        issue(1'b1, Base + 4, 4'b0010, 32'hAABB_CCDD, 1'b0, 1'b0);
        issue(1'b0, Base + 4, 4'hF,    32'h0,         1'b1, 1'b0);
        issue(1'b0, Base,     4'hF,    32'h0,         1'b1, 1'b0);
        drain();
    endtask

    task automatic test_partial_cap();
        issue(1'b1, Base + 8,  4'hF,    32'hC0C0_C0C0, 1'b1, 1'b0);
        issue(1'b1, Base + 12, 4'hF,    32'hD0D0_D0D0, 1'b1, 1'b1);
        issue(1'b0, Base + 8,  4'hF,    32'h0,         1'b1, 1'b0);
        issue(1'b1, Base + 12, 4'b0111, 32'hE1E2_E3E4, 1'b1, 1'b1);
        issue(1'b0, Base + 12, 4'hF,    32'h0,         1'b1, 1'b0);
        issue(1'b1, Base + 12, 4'hF,    32'hD0D0_D0D0, 1'b1, 1'b1);
        issue(1'b1, Base + 12, 4'b0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        issue(1'b0, Base + 12, 4'hF,    32'h0,         1'b1, 1'b0);
        issue(1'b1, Base + 12, 4'hF,    32'hD0D0_D0D0, 1'b1, 1'b1);
        issue(1'b1, Base + 8,  4'hF,    32'h0C0C_0C0C, 1'b1, 1'b1);
        issue(1'b0, Base + 8,  4'hF,    32'h0,         1'b1, 1'b0);
        drain();
    endtask

    task automatic test_back_to_back();
        issue(1'b1, Base + 16, 4'hF, 32'h1600_0016, 1'b1, 1'b0);
        issue(1'b1, Base + 20, 4'hF, 32'h2000_0020, 1'b1, 1'b1);
        issue(1'b0, Base + 16, 4'hF, 32'h0,         1'b0, 1'b0);
        issue(1'b0, Base + 20, 4'hF, 32'h0,         1'b1, 1'b0);
        issue(1'b1, Base + 24, 4'hF, 32'h2400_0024, 1'b0, 1'b0);
        issue(1'b0, Base + 24, 4'hF, 32'h0,         1'b0, 1'b0);
        issue(1'b0, Base + 20, 4'hF, 32'h0,         1'b0, 1'b0);
        issue(1'b0, Base + 16, 4'hF, 32'h0,         1'b1, 1'b0);
        drain();
    endtask

    task automatic test_out_of_range();
        issue(1'b1, Base,             4'hF, 32'h5A5A_0000, 1'b0, 1'b0);
        issue(1'b1, 32'h0,            4'hF, 32'hDEAD_BEEF, 1'b0, 1'b0);
        issue(1'b0, Base,             4'hF, 32'h0,         1'b0, 1'b0);
        issue(1'b0, 32'h0,            4'hF, 32'h0,         1'b0, 1'b0);
        issue(1'b0, Base + 4 * Depth, 4'hF, 32'h0,         1'b0, 1'b0);
        drain();
    endtask

    task automatic test_reset_mid_flight();
        issue(1'b1, Base + 32, 4'hF, 32'h3200_0032, 1'b1, 1'b0);
        issue(1'b1, Base + 36, 4'hF, 32'h3600_0036, 1'b1, 1'b1);
        drain();
        issue(1'b0, Base + 32, 4'hF, 32'h0, 1'b1, 1'b0);
        issue(1'b0, Base + 36, 4'hF, 32'h0, 1'b1, 1'b0);
        @(negedge clk_i);
        rst_ni     = 1'b0;
        data_req_i = 1'b0;
        sb.delete();
        for (int i = 0; i < Depth / 2; i++) tag_m[i] = 1'b0;
        #1;
        n_checks++;
        if (data_rvalid_o !== 1'b0) begin
            n_fail++; $display("FAIL midreset_rvalid: got %b required 0", data_rvalid_o);
        end
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (6) @(negedge clk_i);
        issue(1'b0, Base + 36, 4'hF, 32'h0, 1'b1, 1'b0);
        issue(1'b0, Base + 4,  4'hF, 32'h0, 1'b1, 1'b0);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_cap_tag();
        test_byte_store();
        test_partial_cap();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid_flight();
        repeat (4) @(negedge clk_i);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
